// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad sequencer: strobes columns, debounces press and release of
// one key, and publishes the accepted key plus the last two digits.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] keypad_val,
    output logic       button_on,
    output logic       new_key,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_row_q, cap_row_d;
    logic [7:0]    keypad_val_q, keypad_val_d;
    logic          new_key_q, new_key_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    digit_new_q, digit_new_d;
    logic [3:0]    digit_old_q, digit_old_d;

    logic [3:0] rl;
    logic [3:0] col_oh;
    logic       rl_onehot;
    logic [3:0] code;

    function automatic logic [3:0] decode_key(input logic [3:0] row_oh, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] k;
        r = 2'd0;
        if (row_oh[1]) r = 2'd1;
        if (row_oh[2]) r = 2'd2;
        if (row_oh[3]) r = 2'd3;
        case ({r, col})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SCAN;
            sync1_q      <= 4'b1111;
            sync2_q      <= 4'b1111;
            col_idx_q    <= 2'd0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            cap_row_q    <= 4'd0;
            keypad_val_q <= 8'd0;
            new_key_q    <= 1'b0;
            key_code_q   <= 4'd0;
            digit_new_q  <= 4'd0;
            digit_old_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= rows;
            sync2_q      <= sync1_q;
            col_idx_q    <= col_idx_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            cap_row_q    <= cap_row_d;
            keypad_val_q <= keypad_val_d;
            new_key_q    <= new_key_d;
            key_code_q   <= key_code_d;
            digit_new_q  <= digit_new_d;
            digit_old_q  <= digit_old_d;
        end
    end

    assign rl        = ~sync2_q;
    assign col_oh    = 4'b0001 << col_idx_q;
    assign rl_onehot = (rl != 4'd0) && ((rl & (rl - 4'd1)) == 4'd0);
    assign code      = decode_key(cap_row_q, col_idx_q);

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        cap_row_d    = cap_row_q;
        keypad_val_d = keypad_val_q;
        new_key_d    = 1'b0;
        key_code_d   = key_code_q;
        digit_new_d  = digit_new_q;
        digit_old_d  = digit_old_q;

        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    // Two keys in one column cannot be resolved, so skip the column.
                    if (rl_onehot) begin
                        cap_row_d = rl;
                        cnt_d     = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (rl != cap_row_q) begin
                    state_d = ST_SCAN;
                    dwell_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_HELD;
                    new_key_d    = 1'b1;
                    keypad_val_d = {cap_row_q, col_oh};
                    key_code_d   = code;
                    digit_old_d  = digit_new_q;
                    digit_new_d  = code;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (rl == 4'd0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (rl != 4'd0) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_SCAN;
                    keypad_val_d = 8'd0;
                    col_idx_d    = col_idx_q + 2'd1;
                    dwell_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
                dwell_d = '0;
            end
        endcase
    end

    assign cols       = ~col_oh;
    assign keypad_val = keypad_val_q;
    assign button_on  = (state_q == ST_HELD) || (state_q == ST_RELEASE);
    assign new_key    = new_key_q;
    assign key_code   = key_code_q;
    assign digit_new  = digit_new_q;
    assign digit_old  = digit_old_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives rows from cols, and
// accepted keys are scored against a key-map/history reference model.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows, cols;
    logic [7:0] keypad_val;
    logic       button_on, new_key;
    logic [3:0] key_code, digit_new, digit_old;
    logic [15:0] pressed;

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            if ((pressed[r*4 +: 4] & ~cols) != 4'b0000) rows[r] = 1'b0;
    end

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .keypad_val(keypad_val), .button_on(button_on), .new_key(new_key),
        .key_code(key_code), .digit_new(digit_new), .digit_old(digit_old)
    );

    typedef struct {
        logic [3:0] code;
        logic [7:0] val;
        logic [3:0] dnew;
        logic [3:0] dold;
    } obs_t;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
        logic [7:0] val;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int rd = 0;
    obs_t obs [256];
    obs_t sbq [$];
    logic [3:0] hist [$];
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    vec_t tbl [16];

    always @(negedge clk) begin
        if (reset === 1'b1 && new_key === 1'b1) begin
            if (pulses < 256) obs[pulses] <= '{key_code, keypad_val, digit_new, digit_old};
            pulses <= pulses + 1;
        end
    end

    function automatic logic [15:0] key(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_press(input int r, input int c);
        obs_t e;
        e.code = keymap[r*4 + c];
        e.val  = {4'(1 << r), 4'(1 << c)};
        e.dnew = e.code;
        e.dold = (hist.size() > 0) ? hist[hist.size()-1] : 4'h0;
        hist.push_back(e.code);
        sbq.push_back(e);
    endtask

    task automatic drain();
        obs_t e;
        while (rd < pulses && rd < 256) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_new_key: got code %0h, required no pulse", obs[rd].code);
            end else begin
                e = sbq.pop_front();
                chk("sb_key_code",   32'(obs[rd].code), 32'(e.code));
                chk("sb_keypad_val", 32'(obs[rd].val),  32'(e.val));
                chk("sb_digit_new",  32'(obs[rd].dnew), 32'(e.dnew));
                chk("sb_digit_old",  32'(obs[rd].dold), 32'(e.dold));
            end
            rd++;
        end
    endtask

    task automatic wait_key(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (new_key === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_release(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (button_on === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        sbq.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int p0;
        logic [3:0] prev;

        tbl[0]  = '{0, 0, 4'h1, 8'b0001_0001};
        tbl[1]  = '{3, 3, 4'hD, 8'b1000_1000};
        tbl[2]  = '{0, 1, 4'h2, 8'b0001_0010};
        tbl[3]  = '{0, 2, 4'h3, 8'b0001_0100};
        tbl[4]  = '{0, 3, 4'hA, 8'b0001_1000};
        tbl[5]  = '{1, 0, 4'h4, 8'b0010_0001};
        tbl[6]  = '{1, 1, 4'h5, 8'b0010_0010};
        tbl[7]  = '{1, 2, 4'h6, 8'b0010_0100};
        tbl[8]  = '{1, 3, 4'hB, 8'b0010_1000};
        tbl[9]  = '{2, 0, 4'h7, 8'b0100_0001};
        tbl[10] = '{2, 1, 4'h8, 8'b0100_0010};
        tbl[11] = '{2, 2, 4'h9, 8'b0100_0100};
        tbl[12] = '{2, 3, 4'hC, 8'b0100_1000};
        tbl[13] = '{3, 0, 4'hE, 8'b1000_0001};
        tbl[14] = '{3, 1, 4'h0, 8'b1000_0010};
        tbl[15] = '{3, 2, 4'hF, 8'b1000_0100};

        reset   = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_cols",       32'(cols),       32'hE);
        chk("rst_keypad_val", 32'(keypad_val), 32'h0);
        chk("rst_button_on",  32'(button_on),  32'h0);
        chk("rst_new_key",    32'(new_key),    32'h0);
        chk("rst_key_code",   32'(key_code),   32'h0);
        chk("rst_digits",     32'({digit_new, digit_old}), 32'h0);

        // Idle scan: after n edges the column is (n/4) mod 4.
        reset = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) @(negedge clk);
            chk($sformatf("idle_cols_%0d", n), 32'(cols), 32'(~(4'b0001 << ((n / SD) % 4)) & 4'hF));
            chk($sformatf("idle_new_key_%0d", n), 32'(new_key), 32'h0);
        end
        $display("idle scan: 21 cycles checked");

        // Key 5 held through reset release: sample after edge 7, pulse after edge 16.
        apply_reset();
        pressed = key(1, 1);
        expect_press(1, 1);
        reset = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            chk($sformatf("lat_new_key_%0d", n), 32'(new_key), (n == 16) ? 32'h1 : 32'h0);
            if (n == 16) begin
                chk("lat_keypad_val", 32'(keypad_val), 32'h22);
                chk("lat_key_code",   32'(key_code),   32'h5);
                chk("lat_digit_new",  32'(digit_new),  32'h5);
                chk("lat_button_on",  32'(button_on),  32'h1);
            end
        end
        chk("lat_cols_frozen", 32'(cols), 32'hD);
        pressed = 16'h0;
        wait_release(60, ok);
        chk("lat_release_timeout", 32'(ok), 32'h1);
        chk("lat_release_keypad_val", 32'(keypad_val), 32'h0);
        drain();
        $display("latency key 5: pulse checked 9 cycles after sample");

        // Reset while a key is held.
        pressed = key(2, 2);
        expect_press(2, 2);
        wait_key(80, ok);
        chk("hold_timeout", 32'(ok), 32'h1);
        repeat (3) @(negedge clk);
        drain();
        reset = 1'b0;
        hist.delete();
        #1;
        chk("midrst_cols",       32'(cols),       32'hE);
        chk("midrst_button_on",  32'(button_on),  32'h0);
        chk("midrst_keypad_val", 32'(keypad_val), 32'h0);
        chk("midrst_key_code",   32'(key_code),   32'h0);
        chk("midrst_digits",     32'({digit_new, digit_old}), 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_new_key", 32'(new_key), 32'h0);
        reset = 1'b1;
        expect_press(2, 2);
        wait_key(80, ok);
        chk("midrst_resume_timeout", 32'(ok), 32'h1);
        pressed = 16'h0;
        wait_release(60, ok);
        chk("midrst_release_timeout", 32'(ok), 32'h1);
        drain();
        $display("reset mid-held: outputs cleared, scan resumed");

        // Press bounce on key 5, then a release glitch.
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? key(1, 1) : 16'h0;
            repeat (3) @(negedge clk);
        end
        chk("bounce_no_key", 32'(pulses), 32'(p0));
        pressed = key(1, 1);
        expect_press(1, 1);
        wait_key(80, ok);
        chk("bounce_accept_timeout", 32'(ok), 32'h1);
        repeat (5) @(negedge clk);
        pressed = 16'h0;
        repeat (4) begin @(negedge clk); chk("relglitch_held_a", 32'(button_on), 32'h1); end
        pressed = key(1, 1);
        repeat (2) begin @(negedge clk); chk("relglitch_held_b", 32'(button_on), 32'h1); end
        pressed = 16'h0;
        repeat (8) begin @(negedge clk); chk("relglitch_held_c", 32'(button_on), 32'h1); end
        wait_release(60, ok);
        chk("relglitch_release_timeout", 32'(ok), 32'h1);
        repeat (2) @(negedge clk);
        chk("bounce_one_pulse", 32'(pulses), 32'(p0 + 1));
        drain();
        $display("bounce: one pulse for bounced press and glitched release");

        // Two keys in column 0 are rejected; the single key is taken next pass.
        apply_reset();
        pressed = key(0, 0) | key(2, 0);
        p0 = pulses;
        reset = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 4) begin
                chk("twokey_advanced_cols", 32'(cols), 32'hD);
                pressed = key(0, 0);
            end
        end
        chk("twokey_no_pulse", 32'(pulses), 32'(p0));
        chk("twokey_button_off", 32'(button_on), 32'h0);
        expect_press(0, 0);
        wait_key(80, ok);
        chk("twokey_single_timeout", 32'(ok), 32'h1);
        chk("twokey_single_code", 32'(key_code), 32'h1);
        pressed = 16'h0;
        wait_release(60, ok);
        chk("twokey_release_timeout", 32'(ok), 32'h1);
        drain();
        $display("two keys in col0: rejected, single key accepted");

        // Table of every key; the first two entries form the "1" then "D" sequence.
        apply_reset();
        reset = 1'b1;
        prev  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            pressed = key(tbl[i].r, tbl[i].c);
            expect_press(tbl[i].r, tbl[i].c);
            wait_key(80, ok);
            chk("tbl_timeout",    32'(ok),         32'h1);
            chk("tbl_key_code",   32'(key_code),   32'(tbl[i].code));
            chk("tbl_keypad_val", 32'(keypad_val), 32'(tbl[i].val));
            chk("tbl_digit_new",  32'(digit_new),  32'(tbl[i].code));
            chk("tbl_digit_old",  32'(digit_old),  32'(prev));
            chk("tbl_button_on",  32'(button_on),  32'h1);
            chk("tbl_cols",       32'(cols),       32'(~(4'b0001 << tbl[i].c) & 4'hF));
            prev = tbl[i].code;
            pressed = 16'h0;
            wait_release(60, ok);
            chk("tbl_release_timeout", 32'(ok), 32'h1);
            drain();
            $display("table key r%0d c%0d: code %0h val %b", tbl[i].r, tbl[i].c, key_code, keypad_val);
        end

        // Random keys with short press bounces, checked through the scoreboard.
        for (int t = 0; t < 12; t++) begin
            int r, c, g;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                pressed = key(r, c);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                pressed = 16'h0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            pressed = key(r, c);
            expect_press(r, c);
            wait_key(80, ok);
            chk("rnd_timeout", 32'(ok), 32'h1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            pressed = 16'h0;
            wait_release(60, ok);
            chk("rnd_release_timeout", 32'(ok), 32'h1);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            drain();
            $display("random key r%0d c%0d glitches %0d: code %0h", r, c, g, key_code);
        end

        repeat (5) @(negedge clk);
        drain();
        chk("sb_all_pulses_seen", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
